// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage next-PC generator with BTB+BHT prediction, delay-slot redirect and mispredict recovery
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int BHT_BITS = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   output logic [31:0] pc,
   input  logic        btb_hit,
   input  logic [31:0] btb_target,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   input  logic        res_pred_taken,
   input  logic [31:0] res_pred_target,
   output logic        flush,
   output logic        btb_update,
   output logic [31:0] btb_update_pc,
   output logic [31:0] btb_update_target,
   output logic [31:0] mispredict_cnt
);
   typedef enum logic {SEQ, DELAY} state_t;
   state_t state;
   logic [31:0] pend_target;
   logic [1:0] bht [2**BHT_BITS];
   logic [BHT_BITS-1:0] idx, ridx;
   logic mis, upd_en;
   logic [31:0] corr;
   assign idx = pc[BHT_BITS+1:2];
   assign ridx = res_pc[BHT_BITS+1:2];
   assign pred_taken = (state == SEQ) && btb_hit && bht[idx][1];
   assign pred_target = btb_target;
   assign mis = res_valid && ((res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target));
   assign flush = mis;
   assign corr = res_taken ? res_target : res_pc + 32'd8;
   assign upd_en = res_valid && res_taken && (!res_pred_taken || res_target != res_pred_target);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc <= RESET_PC;
         state <= SEQ;
         pend_target <= '0;
      end else if (mis) begin
         pc <= corr;
         state <= SEQ;
      end else if (!stall) begin
         pc <= (state == DELAY) ? pend_target : pc + 32'd4;
         state <= (state == SEQ && pred_taken) ? DELAY : SEQ;
         if (state == SEQ && pred_taken) pend_target <= btb_target;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < 2**BHT_BITS; i++) bht[i] <= 2'b01;
      end else if (res_valid) begin
         bht[ridx] <= res_taken ? ((bht[ridx] == 2'b11) ? 2'b11 : bht[ridx] + 2'd1)
                                : ((bht[ridx] == 2'b00) ? 2'b00 : bht[ridx] - 2'd1);
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         btb_update <= 1'b0;
         btb_update_pc <= '0;
         btb_update_target <= '0;
         mispredict_cnt <= '0;
      end else begin
         btb_update <= upd_en;
         if (upd_en) begin
            btb_update_pc <= res_pc;
            btb_update_target <= res_target;
         end
         if (mis) mispredict_cnt <= mispredict_cnt + 32'd1;
      end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed plus random checks of fetch_pc_unit against a behavioural model
module tb_fetch_pc_unit;
   localparam logic [31:0] RST = 32'hBFC0_0000;
   logic clk = 0, reset = 1, stall = 0, btb_hit = 0, res_valid = 0, res_taken = 0, res_pred_taken = 0;
   logic [31:0] btb_target = 0, res_pc = 0, res_target = 0, res_pred_target = 0;
   logic pred_taken, flush, btb_update;
   logic [31:0] pc, pred_target, btb_update_pc, btb_update_target, mispredict_cnt;
   int n_pass = 0, n_total = 0;
   logic [31:0] m_pc, m_tgt, m_bu_pc, m_bu_tgt, m_cnt;
   bit m_delay, m_bu;
   int bht_c [64];
   always #5 clk = ~clk;
   fetch_pc_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .pc(pc), .btb_hit(btb_hit), .btb_target(btb_target),
      .pred_taken(pred_taken), .pred_target(pred_target), .res_valid(res_valid), .res_pc(res_pc),
      .res_taken(res_taken), .res_target(res_target), .res_pred_taken(res_pred_taken),
      .res_pred_target(res_pred_target), .flush(flush), .btb_update(btb_update),
      .btb_update_pc(btb_update_pc), .btb_update_target(btb_update_target), .mispredict_cnt(mispredict_cnt)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   function automatic int bidx(input logic [31:0] a);
      return int'((a >> 2) % 64);
   endfunction
   function automatic bit m_pred();
      return !m_delay && btb_hit && bht_c[bidx(m_pc)] >= 2;
   endfunction
   function automatic bit m_mis();
      return res_valid && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target));
   endfunction
   task automatic m_reset();
      m_pc = RST; m_tgt = 0; m_delay = 0; m_bu = 0; m_bu_pc = 0; m_bu_tgt = 0; m_cnt = 0;
      foreach (bht_c[i]) bht_c[i] = 1;
   endtask
   task automatic idle();
      stall = 0; btb_hit = 0; btb_target = 0; res_valid = 0; res_pc = 0; res_taken = 0;
      res_target = 0; res_pred_taken = 0; res_pred_target = 0;
   endtask
   // Model advances one fetch cycle from the architectural rules, then registered outputs are compared.
   task automatic step();
      bit p, m;
      #1;
      check("pred_taken", pred_taken, m_pred());
      check("pred_target", pred_target, btb_target);
      check("flush", flush, m_mis());
      @(posedge clk);
      p = m_pred();
      m = m_mis();
      if (m) begin
         m_pc = res_taken ? res_target : res_pc + 8;
         m_delay = 0;
         m_cnt = m_cnt + 1;
      end else if (!stall) begin
         if (m_delay) begin m_pc = m_tgt; m_delay = 0; end
         else begin
            if (p) begin m_tgt = btb_target; m_delay = 1; end
            m_pc = m_pc + 4;
         end
      end
      if (res_valid) bht_c[bidx(res_pc)] = res_taken ? (bht_c[bidx(res_pc)] == 3 ? 3 : bht_c[bidx(res_pc)] + 1)
                                                     : (bht_c[bidx(res_pc)] == 0 ? 0 : bht_c[bidx(res_pc)] - 1);
      m_bu = res_valid && res_taken && (!res_pred_taken || res_target != res_pred_target);
      if (m_bu) begin m_bu_pc = res_pc; m_bu_tgt = res_target; end
      @(negedge clk);
      check("pc", pc, m_pc);
      check("btb_update", btb_update, m_bu);
      check("btb_update_pc", btb_update_pc, m_bu_pc);
      check("btb_update_target", btb_update_target, m_bu_tgt);
      check("mispredict_cnt", mispredict_cnt, m_cnt);
   endtask
   task automatic goto(input logic [31:0] a);
      idle();
      res_valid = 1; res_pc = 32'hBFC0_0010; res_taken = 1; res_target = a;
      step();
      idle();
   endtask
   task automatic async_reset();
      #2 reset = 1;
      #1 check("async_rst_pc", pc, RST);
      check("async_rst_bu", btb_update, 0);
      m_reset();
      @(negedge clk);
      reset = 0;
   endtask
   initial begin
      idle();
      m_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      check("rst_pc", pc, RST);
      check("rst_bu", btb_update, 0);
      check("rst_cnt", mispredict_cnt, 0);
      #1 check("rst_flush", flush, 0);
      step(); check("seq1", pc, 32'hBFC0_0004);
      step(); check("seq2", pc, 32'hBFC0_0008);
      res_valid = 1; res_pc = 32'hBFC0_0040; res_taken = 0; res_pred_taken = 1;
      #1 check("nt_flush", flush, 1);
      step();
      check("nt_pc", pc, 32'hBFC0_0048);
      check("nt_cnt", mispredict_cnt, 1);
      check("nt_bu", btb_update, 0);
      idle();
      res_valid = 1; res_pc = 32'h80; res_taken = 1; res_target = 32'h200;
      res_pred_taken = 1; res_pred_target = 32'h100;
      #1 check("tm_flush", flush, 1);
      step();
      check("tm_pc", pc, 32'h200);
      check("tm_bu", btb_update, 1);
      check("tm_bu_pc", btb_update_pc, 32'h80);
      check("tm_bu_tgt", btb_update_target, 32'h200);
      idle();
      step(); check("tm_bu_drop", btb_update, 0);
      for (int i = 0; i < 3; i++) begin
         res_valid = 1; res_pc = 32'hBFC0_0100; res_taken = 1; res_target = 32'hBFC0_0200;
         res_pred_taken = 1; res_pred_target = 32'hBFC0_0200;
         step();
      end
      goto(32'hBFC0_0100);
      btb_hit = 1; btb_target = 32'hBFC0_0200;
      #1 check("sat_pred", pred_taken, 1);
      step(); check("sat_slot", pc, 32'hBFC0_0104);
      #1 check("delay_nopred", pred_taken, 0);
      stall = 1;
      for (int i = 0; i < 3; i++) begin step(); check("stall_hold", pc, 32'hBFC0_0104); end
      stall = 0;
      step(); check("stall_release", pc, 32'hBFC0_0200);
      goto(32'hBFC0_0100);
      btb_hit = 1; btb_target = 32'hBFC0_0200;
      step();
      stall = 1; res_valid = 1; res_pc = 32'hBFC0_0504; res_taken = 0; res_pred_taken = 1;
      step(); check("stall_mis", pc, 32'hBFC0_050C);
      goto(32'hBFC0_0100);
      btb_hit = 1; btb_target = 32'hBFC0_0200;
      step(); check("pre_rst_slot", pc, 32'hBFC0_0104);
      idle();
      async_reset();
      check("post_rst_pc", pc, RST);
      step(); check("post_rst_seq", pc, RST + 4);
      step(); check("post_rst_seq2", pc, RST + 8);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 299) == 0) async_reset();
         stall = ($urandom_range(0, 3) == 0);
         btb_hit = $urandom_range(0, 1);
         btb_target = RST | ($urandom_range(0, 15) << 4);
         res_valid = ($urandom_range(0, 2) == 0);
         res_pc = RST | ($urandom_range(0, 15) << 2);
         res_taken = $urandom_range(0, 1);
         res_pred_taken = $urandom_range(0, 1);
         res_target = RST | ($urandom_range(0, 3) << 4);
         res_pred_target = ($urandom_range(0, 1) == 0) ? res_target : RST | ($urandom_range(0, 3) << 4);
         step();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
